// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the single-port memory.
// The arbiter takes the slave view; the CPU side and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_valid, i_data, d_ack, d_valid, d_rdata,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_valid, i_data, d_ack, d_valid, d_rdata,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and data ports.
// Data has priority; a starve counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  logic [3:0]        starve_cnt;
  logic              i_elig;
  logic              d_elig;
  logic              grant_i;
  logic              grant_d;
  logic              grant_read;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] ret_word;
  logic              s1_valid;
  logic              s2_valid;
  port_e             s1_port;
  port_e             s2_port;

  // A port whose ack is high this cycle is updating its payload, so it sits out one edge.
  always_comb begin
    i_elig     = bus.i_req && !bus.i_ack;
    d_elig     = bus.d_req && !bus.d_ack;
    grant_i    = i_elig && (!d_elig || (starve_cnt == 4'(STARVE_LIMIT)));
    grant_d    = d_elig && !grant_i;
    grant_read = grant_i || (grant_d && !bus.d_we);
    grant_addr = grant_i ? bus.i_addr : bus.d_addr;
    ret_word   = bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_valid   <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.i_data    <= '0;
      bus.d_rdata   <= '0;
      starve_cnt    <= 4'd0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s1_port       <= PORT_I;
      s2_port       <= PORT_I;
    end else begin
      bus.i_ack     <= grant_i;
      bus.d_ack     <= grant_d;
      bus.mem_read  <= grant_read;
      bus.mem_write <= grant_d && bus.d_we;
      if (grant_i || grant_d)
        bus.mem_addr <= grant_addr;
      if (grant_d && bus.d_we)
        bus.mem_wdata <= bus.d_wdata;

      if (!bus.i_req || grant_i)
        starve_cnt <= 4'd0;
      else if (grant_d && (starve_cnt != 4'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 4'd1;

      // Tag travels two edges to line up with the word the memory returns.
      s1_valid <= grant_read;
      s1_port  <= grant_d ? PORT_D : PORT_I;
      s2_valid <= s1_valid;
      s2_port  <= s1_port;

      bus.i_valid <= s2_valid && (s2_port == PORT_I);
      bus.d_valid <= s2_valid && (s2_port == PORT_D);
      if (s2_valid && (s2_port == PORT_I))
        bus.i_data <= ret_word;
      if (s2_valid && (s2_port == PORT_D))
        bus.d_rdata <= ret_word;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model with a return queue is
// compared every cycle, and hand-computed literals pin the key scenarios.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 4;
  localparam int MEM_N        = 64;

  typedef struct {
    bit          is_d;
    logic [15:0] data;
    int          due;
  } ret_t;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem       [MEM_N];
  logic [15:0] model_mem [MEM_N];

  // Memory model: samples strobes on the edge after the grant, read word valid the following cycle.
  always @(posedge clk) begin
    if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    if (bus.mem_write) mem[bus.mem_addr[5:0]] = bus.mem_wdata;
  end

  // Reference model state
  int          cyc;
  int          starve;
  bit          i_el, d_el, win_i, win_d;
  logic        m_i_ack, m_d_ack, m_read, m_write, m_i_valid, m_d_valid;
  logic [15:0] m_addr, m_wdata, m_i_data, m_d_data;
  ret_t        ret_q[$];
  ret_t        r;

  // Each read is queued with the value memory holds in grant order and is due two edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; starve = 0;
      m_i_ack = 0; m_d_ack = 0; m_read = 0; m_write = 0;
      m_i_valid = 0; m_d_valid = 0;
      m_addr = 0; m_wdata = 0; m_i_data = 0; m_d_data = 0;
      ret_q.delete();
    end else begin
      cyc++;
      i_el  = bus.i_req && !m_i_ack;
      d_el  = bus.d_req && !m_d_ack;
      win_i = i_el && (!d_el || starve >= STARVE_LIMIT);
      win_d = d_el && !win_i;
      m_i_ack = win_i;
      m_d_ack = win_d;
      m_read  = win_i || (win_d && !bus.d_we);
      m_write = win_d && bus.d_we;
      m_i_valid = 0;
      m_d_valid = 0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        if (r.is_d) begin m_d_valid = 1; m_d_data = r.data; end
        else        begin m_i_valid = 1; m_i_data = r.data; end
      end
      if (win_i) begin
        m_addr = bus.i_addr;
        ret_q.push_back('{1'b0, model_mem[bus.i_addr[5:0]], cyc + 2});
      end
      if (win_d) begin
        m_addr = bus.d_addr;
        if (bus.d_we) begin
          m_wdata = bus.d_wdata;
          model_mem[bus.d_addr[5:0]] = bus.d_wdata;
        end else begin
          ret_q.push_back('{1'b1, model_mem[bus.d_addr[5:0]], cyc + 2});
        end
      end
      if (!bus.i_req || win_i) starve = 0;
      else if (win_d && starve < STARVE_LIMIT) starve++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  int          neg_cyc = 0;
  int          i_valid_cnt = 0, d_valid_cnt = 0, rd_cnt = 0;
  int          last_i_ack_cyc = 0, last_i_valid_cyc = 0;
  logic [15:0] i_log[$];
  logic [15:0] d_log[$];

  always @(negedge clk) begin
    neg_cyc++;
    if (rst === 1'b0) begin
      check_output("i_ack",     bus.i_ack,     m_i_ack);
      check_output("d_ack",     bus.d_ack,     m_d_ack);
      check_output("mem_read",  bus.mem_read,  m_read);
      check_output("mem_write", bus.mem_write, m_write);
      check_output("mem_addr",  bus.mem_addr,  m_addr);
      if (m_write) check_output("mem_wdata", bus.mem_wdata, m_wdata);
      check_output("i_valid",   bus.i_valid,   m_i_valid);
      check_output("d_valid",   bus.d_valid,   m_d_valid);
      check_output("i_data",    bus.i_data,    m_i_data);
      check_output("d_rdata",   bus.d_rdata,   m_d_data);
      if (bus.i_valid) begin i_valid_cnt++; i_log.push_back(bus.i_data); last_i_valid_cyc = neg_cyc; end
      if (bus.d_valid) begin d_valid_cnt++; d_log.push_back(bus.d_rdata); end
      if (bus.i_ack) last_i_ack_cyc = neg_cyc;
      if (bus.mem_read) rd_cnt++;
    end
  end

  task automatic preload(input int a, input logic [15:0] v);
    mem[a[5:0]]       = v;
    model_mem[a[5:0]] = v;
  endtask

  int first_ack, last_ack, max_run;

  // Streams n_i fetches and n_d data accesses, advancing each port's payload on its ack cycle.
  task automatic apply_stimulus(input int n_i, input int i_base, input int n_d, input int d_base,
                                input logic we, input logic [15:0] wbase);
    int i_done = 0, d_done = 0, n = 0, run_d = 0;
    first_ack = -1; last_ack = -1; max_run = 0;
    bus.i_req   = (n_i > 0);
    bus.i_addr  = 16'(i_base);
    bus.d_req   = (n_d > 0);
    bus.d_addr  = 16'(d_base);
    bus.d_we    = we;
    bus.d_wdata = wbase;
    while ((i_done < n_i || d_done < n_d) && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.i_ack || bus.d_ack) begin
        if (first_ack < 0) first_ack = n;
        last_ack = n;
      end
      if (bus.i_ack) begin
        i_done++;
        run_d = 0;
        if (i_done == n_i) bus.i_req = 1'b0;
        else               bus.i_addr = 16'(i_base + i_done);
      end
      if (bus.d_ack) begin
        d_done++;
        if (i_done < n_i) run_d++;
        if (run_d > max_run) max_run = run_d;
        if (d_done == n_d) bus.d_req = 1'b0;
        else begin
          bus.d_addr  = 16'(d_base + d_done);
          bus.d_wdata = wbase + 16'(d_done);
        end
      end
    end
    check_output("stream_done", i_done + d_done, n_i + n_d);
  endtask

  int dv0, iv0, rc0;

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    rst = 1'b1;
    for (int a = 0; a < MEM_N; a++) preload(a, 16'(a));

    // Reset with both ports requesting
    repeat (2) @(negedge clk);
    bus.i_req = 1; bus.i_addr = 16'd2; bus.d_req = 1; bus.d_addr = 16'd3; bus.d_we = 0;
    @(negedge clk);
    check_output("rst_i_ack", bus.i_ack, 0);
    check_output("rst_d_ack", bus.d_ack, 0);
    check_output("rst_i_valid", bus.i_valid, 0);
    check_output("rst_d_valid", bus.d_valid, 0);
    check_output("rst_i_data", bus.i_data, 0);
    check_output("rst_d_rdata", bus.d_rdata, 0);
    check_output("rst_mem_addr", bus.mem_addr, 0);
    check_output("rst_mem_read", bus.mem_read, 0);
    check_output("rst_mem_write", bus.mem_write, 0);
    check_output("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("first_grant_d_ack", bus.d_ack, 1);
    check_output("first_grant_i_ack", bus.i_ack, 0);
    check_output("first_grant_addr", bus.mem_addr, 16'd3);
    bus.d_req = 0;
    @(negedge clk);
    check_output("second_grant_i_ack", bus.i_ack, 1);
    bus.i_req = 0;
    repeat (4) @(negedge clk);
    check_output("post_rst_d_rdata", bus.d_rdata, 16'd3);
    check_output("post_rst_i_data", bus.i_data, 16'd2);

    // Single fetch
    preload(0, 16'hFF1A);
    dv0 = d_valid_cnt; iv0 = i_valid_cnt;
    apply_stimulus(1, 0, 0, 0, 1'b0, 16'h0);
    repeat (4) @(negedge clk);
    check_output("fetch_i_data", bus.i_data, 16'hFF1A);
    check_output("fetch_i_valid_cnt", i_valid_cnt - iv0, 1);
    check_output("fetch_no_d_valid", d_valid_cnt - dv0, 0);
    check_output("fetch_latency", last_i_valid_cyc - last_i_ack_cyc, 2);

    // Write then fetch of the same address
    dv0 = d_valid_cnt;
    apply_stimulus(0, 0, 1, 5, 1'b1, 16'hAAAA);
    apply_stimulus(1, 5, 0, 0, 1'b0, 16'h0);
    repeat (4) @(negedge clk);
    check_output("wr_fetch_i_data", bus.i_data, 16'hAAAA);
    check_output("wr_no_d_valid", d_valid_cnt - dv0, 0);

    // Both ports held: fetch must not wait more than STARVE_LIMIT data grants
    apply_stimulus(3, 20, 10, 40, 1'b0, 16'h0);
    repeat (4) @(negedge clk);
    check_output("starve_bound", (max_run <= STARVE_LIMIT), 1);
    check_output("starve_i_data", bus.i_data, 16'd22);
    check_output("starve_d_rdata", bus.d_rdata, 16'd49);

    // Interleaved streams: one memory read per cycle, no cross-routing
    for (int a = 0; a < 16; a++) preload(a, 16'(a));
    i_log.delete(); d_log.delete();
    rc0 = rd_cnt;
    apply_stimulus(8, 0, 8, 8, 1'b0, 16'h0);
    repeat (4) @(negedge clk);
    check_output("ilv_read_cnt", rd_cnt - rc0, 16);
    check_output("ilv_span", last_ack - first_ack, 15);
    check_output("ilv_i_cnt", i_log.size(), 8);
    check_output("ilv_d_cnt", d_log.size(), 8);
    for (int k = 0; k < 8 && k < i_log.size() && k < d_log.size(); k++) begin
      check_output("ilv_i_word", i_log[k], 16'(k));
      check_output("ilv_d_word", d_log[k], 16'(k + 8));
    end

    // Reset one cycle after a data read ack
    dv0 = d_valid_cnt;
    apply_stimulus(0, 0, 1, 7, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_output("rst_mid_no_d_valid", d_valid_cnt - dv0, 0);
    check_output("rst_mid_d_rdata", bus.d_rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
